// File: rtl/opb_fwd_if.sv
// Operand-B forwarding bus: ID/EX, EX/MEM, MEM/WB and IF/ID hazard inputs plus the registered B operand.
// OPB_FWD_STATS_EN adds the stall_cnt_o statistics output.
interface opb_fwd_if #(
    parameter int DATA_W = 32
);
    logic              ex_valid_i;
    logic [5:0]        ex_op_i;
    logic [4:0]        ex_rt_i;
    logic [15:0]       ex_imm_i;
    logic [DATA_W-1:0] ex_regb_i;
    logic              exm_wr_i;
    logic [4:0]        exm_rd_i;
    logic [DATA_W-1:0] exm_val_i;
    logic              mwb_wr_i;
    logic [4:0]        mwb_rd_i;
    logic [DATA_W-1:0] mwb_val_i;
    logic              id_valid_i;
    logic [4:0]        id_rs_i;
    logic [4:0]        id_rt_i;
    logic [DATA_W-1:0] opb_o;
    logic              opb_valid_o;
    logic [1:0]        fwd_sel_o;
    logic              stall_o;
`ifdef OPB_FWD_STATS_EN
    logic [15:0]       stall_cnt_o;
`endif

    // Valid/ready semantics: there is no back-pressure on this bus; ex_valid_i qualifies the
    // ID/EX slot every cycle and opb_valid_o qualifies opb_o one cycle later.
    modport master (
        output ex_valid_i, ex_op_i, ex_rt_i, ex_imm_i, ex_regb_i,
        output exm_wr_i, exm_rd_i, exm_val_i, mwb_wr_i, mwb_rd_i, mwb_val_i,
        output id_valid_i, id_rs_i, id_rt_i,
`ifdef OPB_FWD_STATS_EN
        input  stall_cnt_o,
`endif
        input  opb_o, opb_valid_o, fwd_sel_o, stall_o
    );

    modport slave (
        input  ex_valid_i, ex_op_i, ex_rt_i, ex_imm_i, ex_regb_i,
        input  exm_wr_i, exm_rd_i, exm_val_i, mwb_wr_i, mwb_rd_i, mwb_val_i,
        input  id_valid_i, id_rs_i, id_rt_i,
`ifdef OPB_FWD_STATS_EN
        output stall_cnt_o,
`endif
        output opb_o, opb_valid_o, fwd_sel_o, stall_o
    );
endinterface

// File: rtl/opb_fwd_unit.sv
// ALU B-operand forwarding mux with load-use stall FSM (IDLE/STALL).
// Optional macro OPB_FWD_STATS_EN adds a saturating 16-bit stall-cycle counter (stall_cnt_o).
module opb_fwd_unit #(
    parameter int DATA_W       = 32,
    parameter int STALL_CYCLES = 1,
    parameter int ZEXT_LOGIC   = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    opb_fwd_if.slave     bus,
    output logic         dbg_stall_state
);
    localparam int CW = $clog2(STALL_CYCLES + 1);

    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MWB = 2'b01;
    localparam logic [1:0] SEL_EXM = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    typedef enum logic {ST_IDLE, ST_STALL} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] opb_q;
    logic [1:0]        sel_q;
    logic              valid_q;

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic              exm_hit;
    logic              mwb_hit;
    logic              hazard;
    logic              stall;
    logic [DATA_W-1:0] nxt_opb;
    logic [1:0]        nxt_sel;

    assign imm_sext = DATA_W'($signed(bus.ex_imm_i));
    assign imm_zext = DATA_W'(bus.ex_imm_i);

    // Register 0 is hard-wired, so a write to it is never a forwarding source.
    assign exm_hit = bus.exm_wr_i && (bus.exm_rd_i == bus.ex_rt_i) && (bus.ex_rt_i != 5'd0);
    assign mwb_hit = bus.mwb_wr_i && (bus.mwb_rd_i == bus.ex_rt_i) && (bus.ex_rt_i != 5'd0);

    assign hazard = bus.ex_valid_i && (bus.ex_op_i == OP_LW) && (bus.ex_rt_i != 5'd0) &&
                    bus.id_valid_i &&
                    ((bus.ex_rt_i == bus.id_rs_i) || (bus.ex_rt_i == bus.id_rt_i));

    // The last STALL cycle (cnt==1) is quiet, giving exactly STALL_CYCLES high cycles per hazard.
    // reset_n gates the output so a held hazard cannot raise stall while in reset.
    assign stall = reset_n &&
                   ((state == ST_IDLE) ? hazard : (cnt != CW'(1)));

    always_comb begin
        nxt_opb = '0;
        nxt_sel = SEL_RF;
        case (bus.ex_op_i)
            OP_ALU: begin
                if (exm_hit) begin
                    nxt_opb = bus.exm_val_i;
                    nxt_sel = SEL_EXM;
                end else if (mwb_hit) begin
                    nxt_opb = bus.mwb_val_i;
                    nxt_sel = SEL_MWB;
                end else begin
                    nxt_opb = bus.ex_regb_i;
                    nxt_sel = SEL_RF;
                end
            end
            OP_ADDI, OP_LW, OP_SW: begin
                nxt_opb = imm_sext;
                nxt_sel = SEL_IMM;
            end
            OP_ANDI, OP_ORI: begin
                nxt_opb = (ZEXT_LOGIC != 0) ? imm_zext : imm_sext;
                nxt_sel = SEL_IMM;
            end
            default: begin
                nxt_opb = '0;
                nxt_sel = SEL_RF;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            opb_q   <= '0;
            sel_q   <= SEL_RF;
            valid_q <= 1'b0;
        end else begin
            opb_q   <= nxt_opb;
            sel_q   <= nxt_sel;
            valid_q <= bus.ex_valid_i && !stall;
            if (state == ST_IDLE) begin
                if (hazard) begin
                    state <= ST_STALL;
                    cnt   <= CW'(STALL_CYCLES);
                end
            end else begin
                // Hazards are not re-evaluated until the FSM is back in IDLE.
                if (cnt == CW'(1)) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    assign bus.opb_o       = opb_q;
    assign bus.fwd_sel_o   = sel_q;
    assign bus.opb_valid_o = valid_q;
    assign bus.stall_o     = stall;
    assign dbg_stall_state = (state == ST_STALL);

`ifdef OPB_FWD_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_opb_fwd_unit.sv
// Bench for opb_fwd_unit: vector table, load-use sequences, async reset mid-stall, random vs. reference model.
module tb_opb_fwd_unit;
    localparam int STALL = 2;

    logic clock;
    logic reset_n;
    logic dbg_stall_state;

    opb_fwd_if #(.DATA_W(32)) bus ();

    opb_fwd_unit #(.DATA_W(32), .STALL_CYCLES(STALL), .ZEXT_LOGIC(1)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .bus             (bus),
        .dbg_stall_state (dbg_stall_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   win_start    = -1000;
    int   stall_total  = 0;
    logic last_stall;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [31:0] regb;
        logic        exm_wr;
        logic [4:0]  exm_rd;
        logic [31:0] exm_val;
        logic        mwb_wr;
        logic [4:0]  mwb_rd;
        logic [31:0] mwb_val;
        logic [31:0] exp_opb;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.ex_valid_i = 1'b0; bus.ex_op_i = 6'h00; bus.ex_rt_i = 5'd0; bus.ex_imm_i = 16'h0;
        bus.ex_regb_i = 32'h0; bus.exm_wr_i = 1'b0; bus.exm_rd_i = 5'd0; bus.exm_val_i = 32'h0;
        bus.mwb_wr_i = 1'b0; bus.mwb_rd_i = 5'd0; bus.mwb_val_i = 32'h0;
        bus.id_valid_i = 1'b0; bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0;
    endtask

    task automatic drive_lw(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        drive_idle();
        bus.ex_valid_i = 1'b1; bus.ex_op_i = 6'h23; bus.ex_rt_i = rt; bus.ex_imm_i = imm;
        bus.id_valid_i = 1'b1; bus.id_rs_i = rs; bus.id_rt_i = 5'd0;
    endtask

    // Reference B operand from the opcode rules: {sel, value}.
    function automatic logic [33:0] ref_opb();
        logic [31:0] sext;
        sext = bus.ex_imm_i[15] ? (32'hFFFF0000 + 32'(bus.ex_imm_i)) : 32'(bus.ex_imm_i);
        if (bus.ex_op_i == 6'h00) begin
            if (bus.ex_rt_i != 0 && bus.exm_wr_i && bus.exm_rd_i == bus.ex_rt_i) return {2'b10, bus.exm_val_i};
            if (bus.ex_rt_i != 0 && bus.mwb_wr_i && bus.mwb_rd_i == bus.ex_rt_i) return {2'b01, bus.mwb_val_i};
            return {2'b00, bus.ex_regb_i};
        end
        if (bus.ex_op_i == 6'h08 || bus.ex_op_i == 6'h23 || bus.ex_op_i == 6'h2B) return {2'b11, sext};
        if (bus.ex_op_i == 6'h0C || bus.ex_op_i == 6'h0D) return {2'b11, 32'(bus.ex_imm_i)};
        return 34'h0;
    endfunction

    // One clock: caller has driven inputs just after a falling edge.
    // A hazard opens a window of STALL+1 cycles in which stall is high for the first STALL.
    task automatic cycle();
        logic        hz;
        logic        exp_stall;
        logic        exp_valid;
        logic [33:0] r;
        #1;
        hz = bus.ex_valid_i && bus.ex_op_i == 6'h23 && bus.ex_rt_i != 0 && bus.id_valid_i &&
             (bus.ex_rt_i == bus.id_rs_i || bus.ex_rt_i == bus.id_rt_i);
        if ((cyc - win_start) > STALL && hz) win_start = cyc;
        exp_stall = (cyc - win_start) < STALL;
        chk("stall_o", 64'(bus.stall_o), 64'(exp_stall));
        last_stall = exp_stall;
        if (exp_stall) stall_total++;
        r = ref_opb();
        exp_valid = bus.ex_valid_i && !exp_stall;
        @(posedge clock);
        #1;
        chk("opb_o", 64'(bus.opb_o), 64'(r[31:0]));
        chk("fwd_sel_o", 64'(bus.fwd_sel_o), 64'(r[33:32]));
        chk("opb_valid_o", 64'(bus.opb_valid_o), 64'(exp_valid));
        cyc++;
    endtask

    initial begin
        int hi;
        int vlow;
        logic [5:0] ops[10];

        vecs[0]  = '{6'h00, 5'd5, 16'h0, 32'h0000DEAD, 1'b1, 5'd5, 32'hAAAA0001, 1'b1, 5'd5, 32'h12345678, 32'hAAAA0001, 2'b10};
        vecs[1]  = '{6'h00, 5'd9, 16'h0, 32'h0000DEAD, 1'b1, 5'd8, 32'h11111111, 1'b1, 5'd9, 32'h5555AAAA, 32'h5555AAAA, 2'b01};
        vecs[2]  = '{6'h00, 5'd3, 16'h0, 32'h0BADF00D, 1'b0, 5'd3, 32'h22222222, 1'b0, 5'd3, 32'h33333333, 32'h0BADF00D, 2'b00};
        vecs[3]  = '{6'h00, 5'd0, 16'h0, 32'hCAFEBABE, 1'b1, 5'd0, 32'h00000011, 1'b1, 5'd0, 32'h00000022, 32'hCAFEBABE, 2'b00};
        vecs[4]  = '{6'h08, 5'd4, 16'h8000, 32'h0, 1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 32'h0, 32'hFFFF8000, 2'b11};
        vecs[5]  = '{6'h0D, 5'd4, 16'h8000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h00008000, 2'b11};
        vecs[6]  = '{6'h0C, 5'd6, 16'hFFFF, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0000FFFF, 2'b11};
        vecs[7]  = '{6'h23, 5'd7, 16'h7FFF, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h00007FFF, 2'b11};
        vecs[8]  = '{6'h2B, 5'd2, 16'hFFFC, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFC, 2'b11};
        vecs[9]  = '{6'h02, 5'd5, 16'h1234, 32'h99999999, 1'b1, 5'd5, 32'h77777777, 1'b0, 5'd0, 32'h0, 32'h00000000, 2'b00};
        vecs[10] = '{6'h03, 5'd5, 16'h1234, 32'h99999999, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h66666666, 32'h00000000, 2'b00};
        vecs[11] = '{6'h3F, 5'd1, 16'hABCD, 32'h88888888, 1'b1, 5'd1, 32'h55555555, 1'b0, 5'd0, 32'h0, 32'h00000000, 2'b00};

        // Reset with a hazard presented: everything must read zero.
        reset_n = 1'b0;
        drive_lw(5'd7, 5'd7, 16'h1111);
        #12;
        chk("rst_opb", 64'(bus.opb_o), 64'h0);
        chk("rst_sel", 64'(bus.fwd_sel_o), 64'h0);
        chk("rst_valid", 64'(bus.opb_valid_o), 64'h0);
        chk("rst_stall", 64'(bus.stall_o), 64'h0);
        chk("rst_state", 64'(dbg_stall_state), 64'h0);
        @(negedge clock);
        drive_idle();
        #2 reset_n = 1'b1;

        // Single load-use hazard: stall exactly STALL cycles.
        hi = 0; vlow = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k < 3) drive_lw(5'd7, 5'd7, 16'h0010);
            else drive_idle();
            cycle();
            hi += int'(last_stall);
            if (k < 2 && bus.opb_valid_o == 1'b0) vlow++;
        end
        chk("lw_stall_len", 64'(hi), 64'(STALL));
        chk("lw_valid_low", 64'(vlow), 64'(STALL));
`ifdef OPB_FWD_STATS_EN
        chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(STALL));
`endif

        // Held hazard: two independent windows back to back.
        hi = 0;
        for (int k = 0; k < 2 * (STALL + 1); k++) begin
            @(negedge clock);
            drive_lw(5'd9, 5'd9, 16'h0020);
            cycle();
            hi += int'(last_stall);
        end
        chk("b2b_stall_len", 64'(hi), 64'(2 * STALL));
        @(negedge clock);
        drive_idle();
        cycle();

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            drive_idle();
            bus.ex_valid_i = 1'b1;    bus.ex_op_i = vecs[i].op;   bus.ex_rt_i = vecs[i].rt;
            bus.ex_imm_i = vecs[i].imm; bus.ex_regb_i = vecs[i].regb;
            bus.exm_wr_i = vecs[i].exm_wr; bus.exm_rd_i = vecs[i].exm_rd; bus.exm_val_i = vecs[i].exm_val;
            bus.mwb_wr_i = vecs[i].mwb_wr; bus.mwb_rd_i = vecs[i].mwb_rd; bus.mwb_val_i = vecs[i].mwb_val;
            cycle();
            chk($sformatf("vec%0d_opb", i), 64'(bus.opb_o), 64'(vecs[i].exp_opb));
            chk($sformatf("vec%0d_sel", i), 64'(bus.fwd_sel_o), 64'(vecs[i].exp_sel));
        end

        // Asynchronous reset in the middle of a stall window.
        @(negedge clock);
        drive_lw(5'd3, 5'd3, 16'h1234);
        cycle();
        #2;
        chk("pre_rst_stall", 64'(bus.stall_o), 64'h1);
        reset_n = 1'b0;
        #1;
        chk("arst_stall", 64'(bus.stall_o), 64'h0);
        chk("arst_valid", 64'(bus.opb_valid_o), 64'h0);
        chk("arst_opb", 64'(bus.opb_o), 64'h0);
        chk("arst_sel", 64'(bus.fwd_sel_o), 64'h0);
        chk("arst_state", 64'(dbg_stall_state), 64'h0);
        @(negedge clock);
        drive_idle();
        #2 reset_n = 1'b1;
        win_start = -1000;
        stall_total = 0;
        @(negedge clock);
        cycle();
        chk("post_rst_state", 64'(dbg_stall_state), 64'h0);

        // Randomized traffic against the reference model.
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F};
        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            bus.ex_valid_i = ($urandom_range(0, 7) != 0);
            bus.ex_op_i    = (n % 17 == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            bus.ex_rt_i    = 5'($urandom_range(0, 7));
            bus.ex_imm_i   = 16'($urandom);
            bus.ex_regb_i  = $urandom;
            bus.exm_wr_i   = 1'($urandom_range(0, 1));
            bus.exm_rd_i   = 5'($urandom_range(0, 7));
            bus.exm_val_i  = $urandom;
            bus.mwb_wr_i   = 1'($urandom_range(0, 1));
            bus.mwb_rd_i   = 5'($urandom_range(0, 7));
            bus.mwb_val_i  = $urandom;
            bus.id_valid_i = 1'($urandom_range(0, 1));
            bus.id_rs_i    = 5'($urandom_range(0, 7));
            bus.id_rt_i    = 5'($urandom_range(0, 7));
            cycle();
        end
`ifdef OPB_FWD_STATS_EN
        chk("stall_cnt_total", 64'(bus.stall_cnt_o), 64'(stall_total));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/opb_fwd_unit.md
OPB_FWD_UNIT -- requirements
Module: opb_fwd_unit

Interface
REQ-001 Parameter DATA_W, default 32: operand and forwarded-value width, legal range 16..64.
REQ-002 Parameter STALL_CYCLES, default 1: load-use bubble length, legal range 1..3.
REQ-003 Parameter ZEXT_LOGIC, default 1: 1 = ANDI/ORI immediates zero-extended; 0 = all immediates sign-extended.
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ex_valid_i  in  1  ID/EX slot holds a valid instruction.
REQ-007 ex_op_i  in  6  ID/EX opcode.
REQ-008 ex_rt_i  in  5  ID/EX rt; B-operand source register.
REQ-009 ex_imm_i  in  16  ID/EX immediate field.
REQ-010 ex_regb_i  in  DATA_W  register-file B value.
REQ-011 exm_wr_i / exm_rd_i / exm_val_i  in  1/5/DATA_W  EX/MEM write enable, destination register, ALU result.
REQ-012 mwb_wr_i / mwb_rd_i / mwb_val_i  in  1/5/DATA_W  MEM/WB write enable, destination register, writeback value.
REQ-013 id_valid_i / id_rs_i / id_rt_i  in  1/5/5  IF/ID instruction valid flag and its source registers.
REQ-014 opb_o  out  DATA_W  registered ALU B operand.
REQ-015 opb_valid_o  out  1  opb_o holds a valid operand; low during bubbles.
REQ-016 fwd_sel_o  out  2  registered source of opb_o: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 immediate.
REQ-017 stall_o  out  1  freeze PC and IF/ID; insert bubble.

Function
REQ-018 Opcodes SHALL be: ALU 0x00, J 0x02, JAL 0x03, ADDI 0x08, ANDI 0x0C, ORI 0x0D, LW 0x23, SW 0x2B.
REQ-019 Immediate class (ADDI, LW, SW, and ANDI/ORI) SHALL select the extended ex_imm_i; ANDI/ORI zero-extend when ZEXT_LOGIC=1, all others sign-extend from bit 15.
REQ-020 ALU class SHALL select EX/MEM when exm_wr_i && exm_rd_i==ex_rt_i && ex_rt_i!=0, else MEM/WB when the same condition holds on mwb_*, else ex_regb_i.
REQ-021 EX/MEM SHALL take priority when both stages match.
REQ-022 Register 0 SHALL never be forwarded.
REQ-023 J, JAL and undefined opcodes SHALL produce opb_o=0 and fwd_sel_o=00.
REQ-024 opb_o, fwd_sel_o and opb_valid_o SHALL update one cycle after inputs are sampled (latency 1).
REQ-025 opb_valid_o SHALL equal the sampled ex_valid_i, forced to 0 in any cycle stall_o is high.
REQ-026 Load-use hazard = ex_valid_i && ex_op_i==LW && ex_rt_i!=0 && id_valid_i && (ex_rt_i==id_rs_i || ex_rt_i==id_rt_i).
REQ-027 FSM SHALL have states IDLE and STALL, with a stall counter of width clog2(STALL_CYCLES+1).
REQ-028 IDLE -> STALL on a hazard; the counter loads STALL_CYCLES.
REQ-029 STALL: the counter decrements each cycle; at 1, return to IDLE.
REQ-030 stall_o SHALL be combinational: high in IDLE when a hazard is present, and in every STALL cycle except the last; the total high time is exactly STALL_CYCLES cycles per hazard.
REQ-031 Hazard detection SHALL be ignored while in STALL; re-evaluation resumes in IDLE.
REQ-032 Back-to-back LWs SHALL produce independent stall windows.
REQ-033 Forwarded values SHALL be passed through unmodified at DATA_W; no truncation and no arithmetic.

Reset
REQ-034 On reset_n low, regardless of clock: opb_o=0, fwd_sel_o=00, opb_valid_o=0, FSM=IDLE, counter=0, stall_o=0.
REQ-035 Reset during STALL SHALL abort the window; normal operation resumes on the first edge after deassertion.

Configuration
REQ-036 Macro OPB_FWD_STATS_EN: when defined, adds output stall_cnt_o (16 bits), counting stall_o-high cycles, saturating at 0xFFFF, cleared by reset.
REQ-037 Without OPB_FWD_STATS_EN, the port and counter SHALL be absent and all other behaviour unchanged.

Verification
REQ-038 ALU, ex_rt_i=5, exm_wr_i=1, exm_rd_i=5, exm_val_i=0xAAAA0001, mwb_rd_i=5 -> next cycle opb_o=0xAAAA0001, fwd_sel_o=10.
REQ-039 ADDI with ex_imm_i=0x8000 -> opb_o=0xFFFF8000, fwd_sel_o=11; ORI with the same immediate (ZEXT_LOGIC=1) -> opb_o=0x00008000.
REQ-040 ALU, ex_rt_i=0, exm_rd_i=0, exm_wr_i=1 -> opb_o=ex_regb_i, fwd_sel_o=00.
REQ-041 LW with ex_rt_i=7 and id_rs_i=7, STALL_CYCLES=2 -> stall_o high exactly 2 cycles, opb_valid_o=0 on the following 2 edges, stall_cnt_o=2.
REQ-042 reset_n pulsed low mid-STALL, asynchronous to clock -> stall_o and opb_valid_o drop immediately; FSM=IDLE after release.
